// File: rtl/regfile_cmd_ctrl.sv
// Decodes write (AA addr data) and read (BB addr) byte frames into register-file strobes and forwards read data to the TX FIFO.
// Write strobe one cycle after the data byte; TX push three cycles after the read address byte; FIFO_FULL stalls the push indefinitely.
module regfile_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_TIMEOUT = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_PUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          addr_bad;

    assign addr_bad = |RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];

    // BUSY is written alongside every transition so it always reflects the state being entered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            TX_D_VLD <= 1'b0;
            ERR      <= 1'b0;
            case (state)
                IDLE: begin
                    if (RX_D_VLD) begin
                        if (RX_P_DATA == OP_WR)      state <= WR_ADDR;
                        else if (RX_P_DATA == OP_RD) state <= RD_ADDR;
                        else                         ERR   <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (RX_D_VLD) begin
                        if (addr_bad) begin
                            ERR   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            state   <= WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData <= RX_P_DATA;
                        WrEn   <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= WR_EXEC;
                    end
                end
                WR_EXEC: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                RD_ADDR: begin
                    if (RX_D_VLD) begin
                        if (addr_bad) begin
                            ERR   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                            RdEn    <= 1'b1;
                            BUSY    <= 1'b1;
                            state   <= RD_EXEC;
                        end
                    end
                end
                RD_EXEC: begin
                    tmo_cnt <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Push is launched straight from the capture so it lands three cycles after the address byte.
                    if (RdData_VLD) begin
                        TX_P_DATA <= RdData;
                        TX_D_VLD  <= !FIFO_FULL;
                        state     <= TX_PUSH;
                    end else if (tmo_cnt == CW'(RD_TIMEOUT - 1)) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                TX_PUSH: begin
                    if (TX_D_VLD) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (!FIFO_FULL) begin
                        TX_D_VLD <= 1'b1;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a behavioural register file and expected-result queues.
module tb_regfile_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic       WrEn, RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_VLD;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       FIFO_FULL = 1'b0;
    logic       BUSY, ERR;

    logic       rd_vld_en = 1'b1;
    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
    int snap_wr, snap_rd, snap_tx;
    logic [7:0]  tx_q [$];
    logic [11:0] wr_q [$];

    regfile_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .RdData(RdData), .RdData_VLD(RdData_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Register file: reg2 = 0x81 and reg3 = 0x20 out of reset, read data one cycle after RdEn.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mem[2]     <= 8'h81;
            mem[3]     <= 8'h20;
            RdData     <= 8'h00;
            RdData_VLD <= 1'b0;
        end else begin
            RdData_VLD <= 1'b0;
            if (WrEn) mem[Address] <= WrData;
            if (RdEn && rd_vld_en) begin
                RdData     <= mem[Address];
                RdData_VLD <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [11:0] w;
        logic [7:0]  t;
        check("wr_rd_exclusive", 32'(WrEn & RdEn), 32'd0);
        if (ERR) n_err++;
        if (RdEn) n_rd++;
        if (WrEn) begin
            n_wr++;
            if (wr_q.size() == 0) check("unexpected_wren", 32'd1, 32'd0);
            else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(Address), 32'(w[11:8]));
                check("wr_data", 32'(WrData), 32'(w[7:0]));
            end
        end
        if (TX_D_VLD) begin
            n_tx++;
            if (tx_q.size() == 0) check("unexpected_tx", 32'd1, 32'd0);
            else begin
                t = tx_q.pop_front();
                check("tx_data", 32'(TX_P_DATA), 32'(t));
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        monitor();
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        cycle();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wren"}, 32'(WrEn), 32'd0);
        check({tag, "_rden"}, 32'(RdEn), 32'd0);
        check({tag, "_addr"}, 32'(Address), 32'd0);
        check({tag, "_wrdata"}, 32'(WrData), 32'd0);
        check({tag, "_txdata"}, 32'(TX_P_DATA), 32'd0);
        check({tag, "_txvld"}, 32'(TX_D_VLD), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd0);
        check({tag, "_err"}, 32'(ERR), 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        send_byte(8'hAA);
        send_byte({4'h0, a});
        send_byte(d);
        check("write_strobe", 32'(WrEn), 32'd1);
        check("write_busy", 32'(BUSY), 32'd1);
        cycle();
        check("write_done_wren", 32'(WrEn), 32'd0);
        check("write_done_idle", 32'(BUSY), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
        tx_q.push_back(exp);
        send_byte(8'hBB);
        send_byte({4'h0, a});
        check("read_strobe", 32'(RdEn), 32'd1);
        check("read_addr", 32'(Address), 32'(a));
        cycle();
        check("read_no_early_tx", 32'(TX_D_VLD), 32'd0);
        cycle();
        check("read_tx_at_3", 32'(TX_D_VLD), 32'd1);
        cycle();
        check("read_done_tx", 32'(TX_D_VLD), 32'd0);
        check("read_done_idle", 32'(BUSY), 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        repeat (3) cycle();
        check_all_zero("reset_held");
        RST = 1'b1;
        cycle();

        // Write then read back; reset values of reg2/reg3; back-to-back frames
        do_write(4'd5, 8'h3C);
        do_read(4'd5, 8'h3C);
        do_read(4'd2, 8'h81);
        do_read(4'd3, 8'h20);

        // Bad opcode and out-of-range address
        snap_wr = n_wr; snap_rd = n_rd;
        send_byte(8'h55);
        check("bad_op_err", 32'(ERR), 32'd1);
        check("bad_op_idle", 32'(BUSY), 32'd0);
        cycle();
        check("bad_op_err_pulse", 32'(ERR), 32'd0);
        send_byte(8'hAA);
        send_byte(8'h10);
        check("bad_addr_err", 32'(ERR), 32'd1);
        cycle();
        check("bad_addr_no_wr", 32'(n_wr - snap_wr), 32'd0);
        check("bad_addr_no_rd", 32'(n_rd - snap_rd), 32'd0);
        do_write(4'd1, 8'h11);

        // FIFO full stalls the push; bytes during BUSY are dropped silently
        FIFO_FULL = 1'b1;
        snap_tx = n_tx;
        tx_q.push_back(8'h11);
        send_byte(8'hBB);
        send_byte(8'h01);
        check("full_rden", 32'(RdEn), 32'd1);
        send_byte(8'h55);
        check("busy_drop_no_err", 32'(ERR), 32'd0);
        repeat (9) cycle();
        check("full_no_tx", 32'(n_tx - snap_tx), 32'd0);
        check("full_busy", 32'(BUSY), 32'd1);
        FIFO_FULL = 1'b0;
        cycle();
        check("full_release_tx", 32'(TX_D_VLD), 32'd1);
        cycle();
        check("full_single_tx", 32'(n_tx - snap_tx), 32'd1);
        check("full_back_idle", 32'(BUSY), 32'd0);

        // Read timeout: ERR four cycles after entering RD_WAIT
        rd_vld_en = 1'b0;
        snap_tx = n_tx;
        send_byte(8'hBB);
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("timeout_no_early_err", 32'(ERR), 32'd0);
        end
        cycle();
        check("timeout_err", 32'(ERR), 32'd1);
        check("timeout_idle", 32'(BUSY), 32'd0);
        cycle();
        check("timeout_no_tx", 32'(n_tx - snap_tx), 32'd0);
        rd_vld_en = 1'b1;

        // Asynchronous reset mid-frame
        snap_wr = n_wr;
        send_byte(8'hAA);
        send_byte(8'h07);
        #2 RST = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        repeat (3) cycle();
        check("midframe_no_wr", 32'(n_wr - snap_wr), 32'd0);
        RST = 1'b1;
        cycle();
        do_write(4'd7, 8'h99);
        do_read(4'd7, 8'h99);
        do_read(4'd2, 8'h81);

        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("err_pulse_total", 32'(n_err), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_cmd_ctrl.md
# regfile_cmd_ctrl

Byte-command controller that sequences the 8-bit register file from the receive path. It decodes write and read command frames arriving as parallel bytes from the UART receiver and drives the register file's WrEn, RdEn, Address and WrData ports. It captures read data and forwards it to the transmit FIFO through a valid/full handshake. It sits between the RX clock-domain synchroniser output and the register file/TX FIFO, all in the CLK domain.

## Interface
- DATA_WIDTH, 8, register and byte width
- ADDR_WIDTH, 4, register-file address width (depth 2^ADDR_WIDTH)
- RD_TIMEOUT, 4, cycles to wait for RdData_VLD after RdEn before abort
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- RdData  in  DATA_WIDTH  register-file read data
- RdData_VLD  in  1  register-file read data valid
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VLD  out  1  one-cycle push strobe to TX FIFO
- FIFO_FULL  in  1  TX FIFO full, no push allowed
- BUSY  out  1  high in every state except IDLE, WR_ADDR, WR_DATA, RD_ADDR
- ERR  out  1  one-cycle pulse on protocol error

## Operation
- Frames: write = 0xAA, addr, data; read = 0xBB, addr.
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_PUSH.
- IDLE: byte 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> ERR pulse, stay IDLE.
- WR_ADDR / RD_ADDR: on byte, if bits [DATA_WIDTH-1:ADDR_WIDTH] nonzero -> ERR pulse, IDLE; else latch Address, go to WR_DATA / RD_EXEC.
- WR_DATA: on byte, latch WrData -> WR_EXEC.
- WR_EXEC: WrEn=1 for exactly this cycle -> IDLE.
- RD_EXEC: RdEn=1 for exactly this cycle -> RD_WAIT, timeout counter cleared.
- RD_WAIT: on RdData_VLD, capture RdData into TX_P_DATA -> TX_PUSH; if counter reaches RD_TIMEOUT without VLD -> ERR pulse, IDLE.
- TX_PUSH: when FIFO_FULL=0, TX_D_VLD=1 one cycle -> IDLE; while FIFO_FULL=1, hold, no timeout.
- WrEn and RdEn are never high in the same cycle.
- Address and WrData hold their last latched values until overwritten by the next frame.
- RX_D_VLD while BUSY=1: byte silently dropped, no ERR, state unaffected.
- RdData_VLD outside RD_WAIT: ignored.
- Reset, asynchronous at any point including mid-frame: state IDLE, every output 0 (WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, BUSY, ERR), timeout counter 0; partially received frame discarded, no write issued.

## Timing
- All outputs are registered.
- Write: WrEn high in the cycle after the data byte's RX_D_VLD cycle; register updated on the following edge.
- Read: RdEn high in the cycle after the address byte's RX_D_VLD cycle. The register file returns RdData_VLD one cycle later. TX_D_VLD follows no earlier than one cycle after that (with FIFO_FULL=0): 3 cycles from the address-byte pulse to TX_D_VLD.
- ERR is asserted in the cycle after the offending RX_D_VLD or timeout expiry.
- Back-to-back frames: the next opcode byte is accepted the cycle the FSM returns to IDLE.

## Test plan
- Reset, then frame AA 05 3C -> single WrEn pulse with Address=5, WrData=0x3C; subsequent read of 5 returns 0x3C.
- Frame BB 02 after reset -> RdEn pulse with Address=2, then TX_D_VLD with TX_P_DATA=0x81 (reg2 reset value); a second frame BB 03 -> TX_P_DATA=0x20.
- Byte 0x55 in IDLE -> ERR pulse, no WrEn/RdEn; then AA 10 -> ERR (address out of range) and return to IDLE.
- BB 01 with FIFO_FULL=1 held 10 cycles -> TX_D_VLD stays 0, BUSY=1; FIFO_FULL drops -> one TX_D_VLD pulse, then IDLE.
- RdData_VLD tied 0 during BB 04 -> ERR exactly RD_TIMEOUT cycles after entering RD_WAIT, no TX_D_VLD.
- RST asserted after AA 07 -> no WrEn ever issued; all outputs 0; next AA 07 99 completes normally.
